uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port PCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port PRESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_done  input  1  one-cycle strobe; rx_data valid in the same cycle.
REQ-007 SHALL have port pop  input  1  consumer (APB read path) removes the head byte.
REQ-008 SHALL have port flush  input  1  synchronous discard of all stored bytes.
REQ-009 SHALL have port ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port rd_data  output  8  head byte (first-word fall-through).
REQ-011 SHALL have port empty  output  1  no stored bytes.
REQ-012 SHALL have port full  output  1  DEPTH bytes stored.
REQ-013 SHALL have port count  output  AW+1  stored byte count, 0..DEPTH.
REQ-014 SHALL have port overrun  output  1  sticky flag: a received byte was dropped.

Function
REQ-015 SHALL hold a DEPTH x 8 storage array, write pointer wr_ptr, read pointer rd_ptr (AW bits each) and count register (AW+1 bits).
REQ-016 SHALL accept a push when rx_done=1 and (count<DEPTH or an accepted pop occurs in the same cycle); it writes rx_data at wr_ptr and increments wr_ptr.
REQ-017 SHALL accept a pop when pop=1 and count>0; it increments rd_ptr. A pop while empty is ignored and changes no state.
REQ-018 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-019 SHALL update count as +1 for push only, -1 for pop only, and leave it unchanged for simultaneous push and pop, including when full.
REQ-020 SHALL drive rd_data combinationally as storage[rd_ptr] when count>0, and 8'h00 when empty.
REQ-021 SHALL present a byte pushed in cycle N on rd_data, with empty=0, from cycle N+1.
REQ-022 SHALL drive empty=(count==0) and full=(count==DEPTH) from the registered count.
REQ-023 SHALL drop rx_data, leaving storage, pointers and count unchanged, when rx_done=1, full=1 and no pop is accepted.
REQ-024 SHALL, on flush=1, set wr_ptr=rd_ptr=0 and count=0 at the next edge; flush overrides push and pop that cycle; storage contents need not be cleared; overrun is not affected.

Reset
REQ-025 SHALL, while PRESET=1, asynchronously force wr_ptr=0, rd_ptr=0, count=0 and overrun=0; outputs then read empty=1, full=0, count=0, rd_data=8'h00.
REQ-026 SHALL discard a byte whose rx_done strobe coincides with PRESET; after PRESET deasserts, the first accepted push lands at entry 0.

Configuration
REQ-027 SHALL implement the overrun flag only when macro UART_RX_FIFO_OVERRUN_EN is defined: each dropped push (REQ-023) sets overrun=1; ovr_clr=1 clears it at the next edge; a drop in the same cycle as ovr_clr leaves overrun=1 (set wins).
REQ-028 SHALL, without UART_RX_FIFO_OVERRUN_EN, tie overrun to 0 and ignore ovr_clr; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then push 8'hA5 -> next cycle rd_data=8'hA5, count=1, empty=0; pop -> empty=1, rd_data=8'h00.
REQ-030 SHALL cover: push 16 bytes 8'h00..8'h0F with DEPTH=16 -> full=1, count=16; 16 pops return 8'h00..8'h0F in order with pointer wrap; then empty=1.
REQ-031 SHALL cover: when full, push 8'hEE without pop -> byte dropped, count=16, overrun=1 with the macro (0 without); ovr_clr -> overrun=0.
REQ-032 SHALL cover: when full, push 8'h77 with a simultaneous pop -> count stays 16 and 8'h77 is read last.
REQ-033 SHALL cover: pop while empty -> no change; flush with simultaneous push at count=5 -> count=0, empty=1.
REQ-034 SHALL cover: PRESET asserted mid-stream at count=7 -> count=0, empty=1, overrun=0 immediately, without waiting for a PCLK edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO between a UART receiver and an APB read path.
// The sticky overrun flag exists only when UART_RX_FIFO_OVERRUN_EN is defined; otherwise it reads 0.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          pop,
    input  logic          flush,
    input  logic          ovr_clr,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun
);

    localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
    localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_drop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_DEPTH);
    assign w_pop_ok  = pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a byte.
    assign w_push_ok = rx_done && (!w_full || w_pop_ok);
    assign w_drop    = rx_done && w_full && !w_pop_ok;

    always_ff @(posedge PCLK) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic r_overrun;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused;

    assign w_unused = ovr_clr ^ w_drop;
    assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16): vector table plus scoreboard-driven sequences.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef UART_RX_FIFO_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic          PCLK;
    logic          PRESET;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          pop;
    logic          flush;
    logic          ovr_clr;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .pop     (pop),
        .flush   (flush),
        .ovr_clr (ovr_clr),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overrun (overrun)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       rxd;
        logic [7:0] d;
        logic       p;
        logic       fl;
        logic       oc;
        logic [4:0] c;
        logic       e;
        logic       f;
        logic [7:0] rd;
        logic       ov;
    } vec_t;

    vec_t       tbl [10];
    int         n_cmp;
    int         n_fail;
    logic [7:0] q [$];
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rxd, input logic [7:0] d, input logic p,
                         input logic fl, input logic oc);
        rx_done = rxd;
        rx_data = d;
        pop     = p;
        flush   = fl;
        ovr_clr = oc;
    endtask

    // One clock with scoreboard bookkeeping; head byte is compared before the edge that pops it.
    task automatic step(input logic rxd, input logic [7:0] d, input logic p,
                        input logic fl, input logic oc, input string name);
        logic pop_ok;
        logic push_ok;
        logic [7:0] exp_b;
        drive(rxd, d, p, fl, oc);
        #1;
        pop_ok  = p && (m_cnt > 0);
        push_ok = rxd && ((m_cnt < DEPTH) || pop_ok);
        if (fl) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (pop_ok) begin
                if (q.size() > 0) begin
                    exp_b = q.pop_front();
                    chk({name, "_head"}, {24'd0, rd_data}, {24'd0, exp_b});
                end
            end
            if (push_ok) q.push_back(d);
            if (push_ok && !pop_ok) m_cnt++;
            if (pop_ok && !push_ok) m_cnt--;
        end
        @(posedge PCLK);
        #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_cnt  = 0;
        PRESET = 1'b1;
        // A byte strobed during reset must not survive it.
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h11, 1'b0};
        tbl[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h22, 1'b0};
        tbl[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h22, 1'b0};
        tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[7] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h99, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h99, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};

        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_rd", {24'd0, rd_data}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        PRESET = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rxd, tbl[i].d, tbl[i].p, tbl[i].fl, tbl[i].oc);
            @(posedge PCLK);
            #1;
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_count", i), {27'd0, count}, {27'd0, tbl[i].c});
            chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].e});
            chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, tbl[i].f});
            chk($sformatf("vec%0d_rd", i), {24'd0, rd_data}, {24'd0, tbl[i].rd});
            chk($sformatf("vec%0d_ovr", i), {31'd0, overrun}, {31'd0, tbl[i].ov});
        end

        // Fill from a non-zero pointer so both pointers wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {27'd0, count}, 32'd16);
        chk("fill_head", {24'd0, rd_data}, 32'h00);

        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "drop");
        chk("drop_count", {27'd0, count}, 32'd16);
        chk("drop_ovr", {31'd0, overrun}, {31'd0, OVR_EN});
        chk("drop_head", {24'd0, rd_data}, 32'h00);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, "drop_clr");
        chk("drop_clr_ovr", {31'd0, overrun}, {31'd0, OVR_EN});
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr");
        chk("clr_ovr", {31'd0, overrun}, 32'd0);

        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, "full_pp");
        chk("full_pp_count", {27'd0, count}, 32'd16);
        chk("full_pp_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_count", {27'd0, count}, 32'd0);
        chk("drain_rd", {24'd0, rd_data}, 32'h00);

        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_empty");
        chk("pop_empty_count", {27'd0, count}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, "five");
        chk("five_count", {27'd0, count}, 32'd5);
        chk("five_head", {24'd0, rd_data}, 32'hC0);
        step(1'b1, 8'hDD, 1'b0, 1'b1, 1'b0, "flush");
        chk("flush_count", {27'd0, count}, 32'd0);
        chk("flush_empty", {31'd0, empty}, 32'd1);

        // Build count=7 with overrun set (when present), then reset between edges.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, "refill");
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, "redrop");
        chk("redrop_ovr", {31'd0, overrun}, {31'd0, OVR_EN});
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "part");
        chk("part_count", {27'd0, count}, 32'd7);
        #1;
        PRESET = 1'b1;
        #1;
        chk("arst_count", {27'd0, count}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_ovr", {31'd0, overrun}, 32'd0);
        chk("arst_rd", {24'd0, rd_data}, 32'h00);
        q.delete();
        m_cnt = 0;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "post");
        chk("post_rd", {24'd0, rd_data}, 32'h5A);
        chk("post_count", {27'd0, count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
